// File: rtl/uart_block_tx_ctrl.sv
// uart_block_tx_ctrl
// ------------------
// Sequencer that feeds one 8*NUM_BYTES-bit block (e.g. an AES-128 state) to a
// byte-wide UART transmitter, most-significant byte first.
//
// Handshake with the transmitter: in SEND the launch strobe o_fTx equals
// i_fTxReady, so a byte launches in the first cycle the transmitter reports
// ready and exactly once. The controller then waits in WAIT for i_fTxDone
// before moving on. Upstream, i_fStart is a one-cycle request that is only
// honoured in IDLE; it is neither queued nor allowed to touch the buffer
// while o_fBusy is high.
//
// Ports:
//   i_Clk      system clock, rising edge
//   i_Rst      asynchronous active-low reset
//   i_fStart   one-cycle request to send i_Block
//   i_Block    block to send, captured when a start is accepted
//   i_fTxReady transmitter idle
//   i_fTxDone  transmitter finished the current byte
//   o_fTx      one-cycle launch strobe to the transmitter
//   o_TxData   byte presented to the transmitter (top byte of the buffer)
//   o_fBusy    high from start acceptance through the o_fDone cycle
//   o_fDone    one-cycle pulse when the whole block has been sent
//   o_ByteCnt  index of the byte in flight (0 = first)
//   o_State    debug view of the FSM state (0 IDLE, 1 SEND, 2 WAIT, 3 DONE)

module uart_block_tx_ctrl #(
  parameter int NUM_BYTES = 16,
  parameter int CNT_W     = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_fStart,
  input  logic [8*NUM_BYTES-1:0] i_Block,
  input  logic                   i_fTxReady,
  input  logic                   i_fTxDone,
  output logic                   o_fTx,
  output logic [7:0]             o_TxData,
  output logic                   o_fBusy,
  output logic                   o_fDone,
  output logic [CNT_W-1:0]       o_ByteCnt,
  output logic [1:0]             o_State
);

  localparam int BLK_W = 8 * NUM_BYTES;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [BLK_W-1:0]   r_buf;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_last;

  assign w_last = (r_cnt == LAST_IDX);

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_fStart)   w_next = ST_SEND;
      ST_SEND: if (i_fTxReady) w_next = ST_WAIT;
      ST_WAIT: begin
        if (i_fTxDone) begin
          w_next = w_last ? ST_DONE : ST_SEND;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Block buffer and byte counter. The buffer shifts left on every completed
  // byte so the next byte is always in the top 8 bits; after the last byte it
  // has shifted out completely and reads zero. The counter is pinned to 0 in
  // IDLE and freezes at the last index through DONE.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (i_fStart) begin
            r_buf <= i_Block;
          end
        end
        ST_WAIT: begin
          if (i_fTxDone) begin
            r_buf <= {r_buf[BLK_W-9:0], 8'h00};
            if (!w_last) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_DONE: r_cnt <= '0;
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    o_fTx   = 1'b0;
    o_fDone = 1'b0;
    o_fBusy = 1'b1;
    case (r_state)
      ST_IDLE: o_fBusy = 1'b0;
      ST_SEND: o_fTx   = i_fTxReady;
      ST_DONE: o_fDone = 1'b1;
      default: ;
    endcase
  end

  assign o_TxData  = r_buf[BLK_W-1 -: 8];
  assign o_ByteCnt = r_cnt;
  assign o_State   = r_state;

endmodule

// File: tb/tb_uart_block_tx_ctrl.sv
// Testbench for uart_block_tx_ctrl. Inputs are driven 1 time unit after the
// rising edge; outputs are sampled on the falling edge. A small behavioural
// transmitter model answers each launch with a Done pulse and reports ready
// again the cycle after Done.

module tb_uart_block_tx_ctrl;

  localparam int NB    = 16;
  localparam int BW    = 8 * NB;
  localparam int CW    = 4;
  localparam int T_MAX = 2000;

  // ---------------------------------------------------------------- clock/reset
  logic i_Clk = 1'b0;
  logic i_Rst;
  always #5 i_Clk = ~i_Clk;

  // ---------------------------------------------------------------- DUT
  logic          i_fStart;
  logic [BW-1:0] i_Block;
  logic          i_fTxReady;
  logic          i_fTxDone;
  logic          o_fTx;
  logic [7:0]    o_TxData;
  logic          o_fBusy;
  logic          o_fDone;
  logic [CW-1:0] o_ByteCnt;
  logic [1:0]    o_State;

  uart_block_tx_ctrl #(.NUM_BYTES(NB), .CNT_W(CW)) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_fStart   (i_fStart),
    .i_Block    (i_Block),
    .i_fTxReady (i_fTxReady),
    .i_fTxDone  (i_fTxDone),
    .o_fTx      (o_fTx),
    .o_TxData   (o_TxData),
    .o_fBusy    (o_fBusy),
    .o_fDone    (o_fDone),
    .o_ByteCnt  (o_ByteCnt),
    .o_State    (o_State)
  );

  // ---------------------------------------------------------------- UART model
  logic m_busy    = 1'b0;
  logic m_done    = 1'b0;
  int   m_timer   = 0;
  logic stall     = 1'b0;
  logic inj_done  = 1'b0;
  logic tx_seen   = 1'b0;

  assign i_fTxReady = ~m_busy & ~stall;
  assign i_fTxDone  = m_done | inj_done;

  always @(posedge i_Clk) begin
    #1;
    m_done = 1'b0;
    if (tx_seen) begin
      m_busy  = 1'b1;
      m_timer = 20;
    end else if (m_busy) begin
      if (m_timer == 0) begin
        m_busy = 1'b0;
      end else begin
        m_timer = m_timer - 1;
        if (m_timer == 0) m_done = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  logic [CW+7:0] exp_q[$];
  int            exp_done = 0;
  int            n_checks = 0;
  int            n_fail   = 0;
  logic          prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected {count,byte} per launch strobe.
  always @(negedge i_Clk) begin
    logic [CW+7:0] e;
    tx_seen = o_fTx;
    if (i_Rst) begin
      if (prev_done) check("busy_after_done", {31'd0, o_fBusy}, 32'd0);
      if (o_fTx) begin
        if (exp_q.size() == 0) begin
          check("extra_ftx", {31'd0, o_fTx}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", {20'd0, o_ByteCnt, o_TxData}, {20'd0, e});
        end
      end
      if (o_fDone) begin
        check("done_expected", {31'd0, exp_done > 0}, 32'd1);
        check("done_bytes_left", exp_q.size(), 32'd0);
        check("done_cnt", {28'd0, o_ByteCnt}, 32'd15);
        check("done_busy", {31'd0, o_fBusy}, 32'd1);
        if (exp_done > 0) exp_done--;
      end
    end
    prev_done = o_fDone;
  end

  // ---------------------------------------------------------------- drivers
  // Call 1 time unit after a rising edge with the DUT idle.
  task automatic start_block(input logic [BW-1:0] blk);
    i_fStart = 1'b1;
    i_Block  = blk;
    for (int k = 0; k < NB; k++) begin
      exp_q.push_back({CW'(k), blk[8*(NB-k)-1 -: 8]});
    end
    exp_done++;
    @(posedge i_Clk); #1;
    i_fStart = 1'b0;
    i_Block  = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_done(input string name);
    int t;
    for (t = 0; t < T_MAX; t++) begin
      @(negedge i_Clk);
      if (o_fDone) break;
    end
    check(name, {31'd0, t < T_MAX}, 32'd1);
  endtask

  task automatic drive_edge();
    @(posedge i_Clk); #1;
  endtask

  // ---------------------------------------------------------------- stimulus
  localparam logic [BW-1:0] B_NOM = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [BW-1:0] B_3   = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [BW-1:0] B_4   = 128'hDEADBEEFCAFEF00D13579BDF2468ACE0;
  localparam logic [BW-1:0] B_5   = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
  localparam logic [BW-1:0] B_6   = 128'h5A5A0001C3C3FFFE8001700E12344321;
  localparam logic [BW-1:0] B_A5  = {NB{8'hA5}};

  initial begin
    int t;
    i_Rst    = 1'b0;
    i_fStart = 1'b0;
    i_Block  = '0;

    // Reset state
    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk);
    check("rst_ftx",   {31'd0, o_fTx},     32'd0);
    check("rst_data",  {24'd0, o_TxData},  32'd0);
    check("rst_busy",  {31'd0, o_fBusy},   32'd0);
    check("rst_done",  {31'd0, o_fDone},   32'd0);
    check("rst_cnt",   {28'd0, o_ByteCnt}, 32'd0);
    i_Rst = 1'b1;

    // Nominal block
    drive_edge();
    start_block(B_NOM);
    wait_done("nom_timeout");
    @(negedge i_Clk);
    check("nom_idle_data", {24'd0, o_TxData},  32'd0);
    check("nom_idle_cnt",  {28'd0, o_ByteCnt}, 32'd0);

    // Ready stall at byte 3, with a spurious Done injected while in SEND
    drive_edge();
    start_block(B_NOM);
    for (t = 0; t < T_MAX; t++) begin
      @(negedge i_Clk);
      if (o_ByteCnt == 2 && i_fTxDone) break;
    end
    check("stall_wait_timeout", {31'd0, t < T_MAX}, 32'd1);
    drive_edge();
    stall = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge i_Clk);
      check("stall_ftx",  {31'd0, o_fTx},     32'd0);
      check("stall_data", {24'd0, o_TxData},  32'h33);
      check("stall_cnt",  {28'd0, o_ByteCnt}, 32'd3);
      inj_done = (i == 20);
    end
    inj_done = 1'b0;
    drive_edge();
    stall = 1'b0;
    @(negedge i_Clk);
    check("stall_release_ftx", {31'd0, o_fTx}, 32'd1);
    wait_done("stall_timeout");

    // Start while busy, start in DONE cycle, start in the following cycle
    drive_edge();
    start_block(B_3);
    for (t = 0; t < T_MAX; t++) begin
      @(negedge i_Clk);
      if (o_ByteCnt == 5) break;
    end
    check("busy_wait_timeout", {31'd0, t < T_MAX}, 32'd1);
    drive_edge();
    i_fStart = 1'b1;
    i_Block  = B_A5;
    drive_edge();
    i_fStart = 1'b0;
    for (t = 0; t < T_MAX; t++) begin
      @(negedge i_Clk);
      if (o_ByteCnt == 15 && i_fTxDone) break;
    end
    check("last_wait_timeout", {31'd0, t < T_MAX}, 32'd1);
    drive_edge();
    i_fStart = 1'b1;
    i_Block  = B_A5;
    @(negedge i_Clk);
    check("done_cycle", {31'd0, o_fDone}, 32'd1);
    drive_edge();
    start_block(B_4);
    wait_done("after_done_timeout");

    // Spurious Done in IDLE
    @(negedge i_Clk);
    inj_done = 1'b1;
    @(negedge i_Clk);
    inj_done = 1'b0;
    @(negedge i_Clk);
    check("idle_done_cnt",  {28'd0, o_ByteCnt}, 32'd0);
    check("idle_done_busy", {31'd0, o_fBusy},   32'd0);
    check("idle_done_data", {24'd0, o_TxData},  32'd0);

    // Reset during WAIT of byte 7
    drive_edge();
    start_block(B_5);
    for (t = 0; t < T_MAX; t++) begin
      @(negedge i_Clk);
      if (o_ByteCnt == 7 && m_busy && !i_fTxDone) break;
    end
    check("rst_wait_timeout", {31'd0, t < T_MAX}, 32'd1);
    #2;
    i_Rst = 1'b0;
    #1;
    check("mid_rst_ftx",  {31'd0, o_fTx},     32'd0);
    check("mid_rst_data", {24'd0, o_TxData},  32'd0);
    check("mid_rst_busy", {31'd0, o_fBusy},   32'd0);
    check("mid_rst_done", {31'd0, o_fDone},   32'd0);
    check("mid_rst_cnt",  {28'd0, o_ByteCnt}, 32'd0);
    exp_q.delete();
    exp_done = 0;
    repeat (3) @(negedge i_Clk);
    i_Rst = 1'b1;
    for (t = 0; t < T_MAX; t++) begin
      @(negedge i_Clk);
      if (!m_busy) break;
    end
    check("rst_model_idle", {31'd0, t < T_MAX}, 32'd1);
    drive_edge();
    start_block(B_6);
    wait_done("after_rst_timeout");

    // Back-to-back all-ones then all-zeros
    drive_edge();
    start_block({NB{8'hFF}});
    wait_done("ones_timeout");
    drive_edge();
    start_block({NB{8'h00}});
    wait_done("zeros_timeout");

    // Final report
    repeat (30) @(negedge i_Clk);
    check("end_bytes_left", exp_q.size(), 32'd0);
    check("end_done_left",  exp_done,     32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
